// File: rtl/pcw_video_fetch.sv
// Per-line video fetch: reads the roller RAM entry, prefetches screen bytes into a
// small FIFO and shifts them out MSB-first as a 1bpp mono pixel stream.
module pcw_video_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LINE_BYTES = 90
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_linestart,
  input  logic        i_active,
  input  logic        i_vblank,
  input  logic [10:0] i_x,
  input  logic [8:0]  i_y,
  input  logic [16:0] i_roller_base,
  input  logic [7:0]  i_scroll,
  input  logic        i_invert,
  input  logic        i_disp_en,
  output logic        o_mem_req,
  output logic [16:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_pixel,
  output logic        o_underrun
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(LINE_BYTES + 1);

  typedef enum logic [2:0] {IDLE, ROLL_LO, ROLL_HI, FETCH, DRAIN} state_t;

  state_t        state, state_d;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, fill_after;
  logic [CW-1:0] col, col_d;
  logic [7:0]    roll_lo;
  logic [16:0]   line_base, roll_addr, roll_now;
  logic          restart, restart_d;
  logic          req_d;
  logic [16:0]   addr_d;
  logic          flush, push, pop, lo_ld, base_ld;
  logic          line_start, ack, pending, slot0;
  logic [7:0]    sh, sh_d, sum8;
  logic          pix, underrun_set;
  logic          unused;

  assign unused     = ^{i_x[10:3], i_y[8]};
  assign line_start = i_pix_stb & i_linestart;
  assign ack        = o_mem_req & i_mem_ack;
  assign pending    = o_mem_req & ~i_mem_ack;
  assign sum8       = i_y[7:0] + i_scroll;
  assign roll_now   = i_roller_base + {8'd0, sum8, 1'b0};

  assign slot0        = i_pix_stb & i_active & (i_x[2:0] == 3'd0);
  assign pop          = slot0 & (count != '0);
  assign underrun_set = slot0 & (count == '0);

  always_comb begin
    pix  = sh[7];
    sh_d = sh;
    if (i_pix_stb && i_active) begin
      if (i_x[2:0] == 3'd0) begin
        if (count != '0) begin
          pix  = fifo[rd_ptr][7];
          sh_d = {fifo[rd_ptr][6:0], 1'b0};
        end else begin
          pix  = 1'b0;
          sh_d = '0;
        end
      end else begin
        sh_d = {sh[6:0], 1'b0};
      end
    end
  end

  // Linestart has priority over every state; mid-line restarts go through DRAIN
  // so the outstanding read is retired (and its data dropped) before the roller read.
  always_comb begin
    state_d    = state;
    req_d      = o_mem_req;
    addr_d     = o_mem_addr;
    col_d      = col;
    restart_d  = restart;
    flush      = 1'b0;
    push       = 1'b0;
    lo_ld      = 1'b0;
    base_ld    = 1'b0;
    fill_after = count - (PW+1)'(pop);
    if (line_start) begin
      if (i_vblank) begin
        flush     = 1'b1;
        restart_d = 1'b0;
        if (pending) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end else if (state == IDLE) begin
        flush   = 1'b1;
        col_d   = '0;
        state_d = ROLL_LO;
        req_d   = 1'b1;
        addr_d  = roll_now;
      end else begin
        restart_d = 1'b1;
        state_d   = DRAIN;
        if (!pending) req_d = 1'b0;
      end
    end else begin
      case (state)
        IDLE: req_d = 1'b0;
        ROLL_LO: begin
          if (ack) begin
            lo_ld   = 1'b1;
            state_d = ROLL_HI;
            addr_d  = roll_addr + 17'd1;
          end
        end
        ROLL_HI: begin
          if (ack) begin
            base_ld = 1'b1;
            col_d   = '0;
            state_d = FETCH;
            addr_d  = {i_mem_data, roll_lo, 1'b0};
          end
        end
        FETCH: begin
          if (ack) begin
            push       = 1'b1;
            col_d      = col + CW'(1);
            fill_after = count - (PW+1)'(pop) + (PW+1)'(1);
          end
          if (pending) begin
            req_d = 1'b1;
          end else if (col_d == CW'(LINE_BYTES)) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else if (fill_after < (PW+1)'(FIFO_DEPTH)) begin
            req_d  = 1'b1;
            addr_d = line_base + 17'({col_d, 3'b000});
          end else begin
            req_d = 1'b0;
          end
        end
        DRAIN: begin
          if (!pending) begin
            if (restart) begin
              flush   = 1'b1;
              col_d   = '0;
              state_d = ROLL_LO;
              req_d   = 1'b1;
              addr_d  = roll_addr;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      col        <= '0;
      restart    <= 1'b0;
      roll_lo    <= '0;
      line_base  <= '0;
      roll_addr  <= '0;
    end else begin
      state      <= state_d;
      o_mem_req  <= req_d;
      o_mem_addr <= addr_d;
      col        <= col_d;
      restart    <= restart_d;
      if (line_start) roll_addr <= roll_now;
      if (lo_ld) roll_lo <= i_mem_data;
      if (base_ld) line_base <= {i_mem_data, roll_lo, 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !flush && count == (PW+1)'(FIFO_DEPTH)));
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !flush) fifo[wr_ptr] <= i_mem_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh         <= '0;
      o_pixel    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      sh <= sh_d;
      if (i_pix_stb) o_pixel <= i_active ? ((pix ^ i_invert) & i_disp_en) : 1'b0;
      if (underrun_set) o_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcw_video_fetch.sv
// Bench for pcw_video_fetch: table vectors, randomized lines against an arithmetic
// line model, and hand-written drain / underrun / reset / vblank sequences.
module tb_pcw_video_fetch;
  localparam int HTOTAL = 800;
  localparam int HSTART = 40;
  localparam int NPIX   = 720;
  localparam int NB     = 90;
  localparam int MEMSZ  = 131072;

  logic        clk = 1'b0;
  logic        rst, stb, ls, active, vblank, invert, disp_en;
  logic [10:0] x;
  logic [8:0]  y;
  logic [16:0] rb;
  logic [7:0]  scroll;
  logic        mem_req, mem_ack, pixel, underrun;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;

  always #5 clk = ~clk;

  pcw_video_fetch #(.FIFO_DEPTH(4), .LINE_BYTES(90)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_linestart(ls), .i_active(active),
    .i_vblank(vblank), .i_x(x), .i_y(y), .i_roller_base(rb), .i_scroll(scroll),
    .i_invert(invert), .i_disp_en(disp_en), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_pixel(pixel), .o_underrun(underrun)
  );

  typedef struct {
    logic [16:0] rb;
    logic [7:0]  sc;
    logic [8:0]  y;
    logic        inv;
    logic        en;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  b0;
    logic [16:0] exp_roll;
    logic [16:0] exp_base;
    logic [7:0]  exp_pix0;
  } vec_t;

  logic [7:0]  mem [MEMSZ];
  logic        got [NPIX];
  logic [16:0] acked [$];
  vec_t        tv [6];
  int          n_vec = 0, n_bad = 0, stab_err = 0;
  bit          hold_ack = 1'b0;
  int          max_lat = 0;
  bit          r_busy = 1'b0;
  int          r_cnt = 0;
  logic [16:0] r_cur = '0;

  // Memory slave: one request at a time, random latency, checks request stability.
  initial begin
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        r_busy = 1'b0;
        mem_ack = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          r_busy = 1'b0;
        end
        if (!r_busy && mem_req) begin
          r_busy = 1'b1;
          r_cur = mem_addr;
          r_cnt = $urandom_range(0, max_lat);
        end else if (r_busy && (!mem_req || mem_addr != r_cur)) begin
          stab_err++;
        end
        if (r_busy && !hold_ack) begin
          if (r_cnt == 0) begin
            mem_ack = 1'b1;
            mem_data = mem[r_cur];
            acked.push_back(r_cur);
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] acked_at(input int i);
    if (i < acked.size()) return 32'(acked[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] got_byte(input int c);
    logic [7:0] gb;
    for (int b = 0; b < 8; b++) gb[7-b] = got[8*c+b];
    return gb;
  endfunction

  task automatic run_line(input int nh, input bit vb, input int hold_at, input int release_at);
    acked.delete();
    for (int h = 0; h < nh; h++) begin
      if (h == hold_at) hold_ack = 1'b1;
      if (h == release_at) hold_ack = 1'b0;
      stb = 1'b1;
      ls = (h == 0);
      vblank = vb;
      active = !vb && h >= HSTART && h < HSTART + NPIX;
      x = active ? 11'(h - HSTART) : '0;
      @(posedge clk); #1;
      if (active) got[h - HSTART] = pixel;
      stb = 1'b0;
      ls = 1'b0;
      @(posedge clk); #1;
    end
    active = 1'b0;
    vblank = 1'b0;
  endtask

  // Line model: roller entry -> base -> 90 byte columns, 8 pixels each MSB first.
  task automatic check_line(input string tag, input int skip);
    int r, bs, ea;
    logic [7:0] lo, hi, eb;
    r  = (int'(rb) + 2 * ((int'(y) + int'(scroll)) % 256)) % MEMSZ;
    lo = mem[r];
    hi = mem[(r + 1) % MEMSZ];
    bs = (int'(hi) * 256 + int'(lo)) * 2;
    check($sformatf("%s nreads", tag), 32'(acked.size()), 32'(NB + 2 + skip));
    for (int i = 0; i < NB + 2; i++) begin
      ea = (i == 0) ? r : (i == 1) ? (r + 1) % MEMSZ : (bs + 8 * (i - 2)) % MEMSZ;
      check($sformatf("%s addr%0d", tag, i), acked_at(i + skip), 32'(ea));
    end
    for (int c = 0; c < NB; c++) begin
      eb = disp_en ? (mem[(bs + 8 * c) % MEMSZ] ^ {8{invert}}) : 8'h00;
      check($sformatf("%s byte%0d", tag, c), 32'(got_byte(c)), 32'(eb));
    end
    check($sformatf("%s underrun", tag), 32'(underrun), 32'd0);
  endtask

  initial begin
    int ones;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    rst = 1'b1; stb = 1'b0; ls = 1'b0; active = 1'b0; vblank = 1'b0; x = '0;
    y = '0; rb = '0; scroll = '0; invert = 1'b0; disp_en = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset pixel", 32'(pixel), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    tv[0] = '{17'h01000, 8'h00, 9'd5,   1'b0, 1'b1, 8'h34, 8'h12, 8'hA5, 17'h0100A, 17'h02468, 8'hA5};
    tv[1] = '{17'h01000, 8'h00, 9'd5,   1'b1, 1'b1, 8'h34, 8'h12, 8'hA5, 17'h0100A, 17'h02468, 8'h5A};
    tv[2] = '{17'h01000, 8'h00, 9'd5,   1'b0, 1'b0, 8'h34, 8'h12, 8'hA5, 17'h0100A, 17'h02468, 8'h00};
    tv[3] = '{17'h01000, 8'hFE, 9'd3,   1'b0, 1'b1, 8'h00, 8'h30, 8'h3C, 17'h01002, 17'h06000, 8'h3C};
    tv[4] = '{17'h1FFFE, 8'h00, 9'd1,   1'b0, 1'b1, 8'hFF, 8'hFF, 8'h81, 17'h00000, 17'h1FFFE, 8'h81};
    tv[5] = '{17'h00200, 8'h01, 9'd255, 1'b1, 1'b1, 8'h00, 8'h08, 8'hFF, 17'h00200, 17'h01000, 8'h00};

    for (int i = 0; i < 6; i++) begin
      rb = tv[i].rb; scroll = tv[i].sc; y = tv[i].y; invert = tv[i].inv; disp_en = tv[i].en;
      max_lat = i % 4;
      mem[tv[i].exp_roll] = tv[i].lo;
      mem[(int'(tv[i].exp_roll) + 1) % MEMSZ] = tv[i].hi;
      mem[tv[i].exp_base] = tv[i].b0;
      run_line(HTOTAL, 1'b0, -1, -1);
      check($sformatf("tv%0d roll", i), acked_at(0), 32'(tv[i].exp_roll));
      check($sformatf("tv%0d base", i), acked_at(2), 32'(tv[i].exp_base));
      check($sformatf("tv%0d pix0", i), 32'(got_byte(0)), 32'(tv[i].exp_pix0));
      check_line($sformatf("tv%0d", i), 0);
    end

    for (int i = 0; i < 8; i++) begin
      rb = 17'($urandom); scroll = 8'($urandom); y = 9'($urandom_range(0, 255));
      invert = 1'($urandom); disp_en = ($urandom_range(0, 3) != 0);
      max_lat = $urandom_range(0, 3);
      run_line(HTOTAL, 1'b0, -1, -1);
      check_line($sformatf("rnd%0d", i), 0);
    end

    // Linestart during vertical blanking from idle must not touch memory.
    run_line(20, 1'b1, -1, -1);
    check("vblank reads", 32'(acked.size()), 32'd0);
    check("vblank req", 32'(mem_req), 32'd0);

    // Linestart while a byte fetch waits for ack; ack arrives ~10 cycles later.
    max_lat = 0; invert = 1'b0; disp_en = 1'b1;
    y = 9'd17; scroll = 8'h20; rb = 17'h04000;
    run_line(60, 1'b0, 45, -1);
    check("drain pending req", 32'(mem_req), 32'd1);
    y = 9'd99;
    run_line(HTOTAL, 1'b0, -1, 5);
    check_line("drain", 1);

    // Asynchronous reset in the middle of the active area.
    max_lat = 1; invert = 1'b1; y = 9'd40;
    run_line(300, 1'b0, -1, -1);
    #2 rst = 1'b1;
    #1;
    check("midreset mem_req", 32'(mem_req), 32'd0);
    check("midreset mem_addr", 32'(mem_addr), 32'd0);
    check("midreset pixel", 32'(pixel), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    invert = 1'b0; y = 9'd41;
    run_line(HTOTAL, 1'b0, -1, -1);
    check_line("postreset", 0);

    // Ack withheld for 400 strobes past active start: black pixels, sticky underrun.
    y = 9'd77;
    run_line(HTOTAL, 1'b0, 0, HSTART + 400);
    ones = 0;
    for (int i = 0; i < 400; i++) ones += int'(got[i]);
    check("underrun black pixels", 32'(ones), 32'd0);
    check("underrun set", 32'(underrun), 32'd1);
    run_line(20, 1'b1, -1, -1);
    check("underrun sticky", 32'(underrun), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("underrun cleared", 32'(underrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("request stability", 32'(stab_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pcw_video_fetch.md
Name: pcw_video_fetch

Overview:
- Downstream consumer of the PCW video sync generator; turns per-line timing into a 1-bit-per-pixel mono stream for the 720x256 display.
- At each line start it reads the line's 16-bit roller RAM entry (through the shared memory read port) and prefetches 90 screen bytes into a 4-entry FIFO.
- It shifts the bytes out MSB-first, one pixel per pixel strobe, during the active area.

Parameters:
- FIFO_DEPTH, 4, screen-byte FIFO entries (power of 2, minimum 2)
- LINE_BYTES, 90, bytes fetched per line (720/8)

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset: asynchronous, active-high
- i_pix_stb  in  1  pixel clock strobe (same as sync generator)
- i_linestart  in  1  high for one strobe at h_count==0
- i_active  in  1  active pixel area
- i_vblank  in  1  vertical blanking
- i_x  in  11  active pixel x, 0..719
- i_y  in  9  active line y, 0..255
- i_roller_base  in  17  roller RAM byte address (port F5 value * 512)
- i_scroll  in  8  vertical scroll offset (port F6)
- i_invert  in  1  reverse video (port F7 bit 7)
- i_disp_en  in  1  display enable; 0 forces black
- o_mem_req  out  1  memory read request
- o_mem_addr  out  17  memory byte address
- i_mem_ack  in  1  one-cycle acknowledge; i_mem_data valid in the same cycle
- i_mem_data  in  8  read data
- o_pixel  out  1  pixel value, registered, valid one strobe after its i_x
- o_underrun  out  1  sticky: the shifter needed a byte and the FIFO was empty

Behaviour:
- Reset values: o_mem_req=0, o_mem_addr=0, o_pixel=0, o_underrun=0. FIFO empty, shift register 0, FSM IDLE.
- Memory handshake:
  - Only one request outstanding.
  - o_mem_req and o_mem_addr stay stable until the cycle i_mem_ack=1.
  - o_mem_req drops in the cycle after ack unless a new request is issued.
- Roller entry address = i_roller_base + 2*((i_y + i_scroll) mod 256), 17-bit wrap. Low byte is at the even address, high byte at +1.
- Line base address = {entry[15:0],1'b0}. Byte column c (0..89) address = base + 8*c, mod 2^17.
- FSM states: IDLE, ROLL_LO, ROLL_HI, FETCH, DRAIN.
  - IDLE -> ROLL_LO on i_pix_stb & i_linestart & ~i_vblank. The FIFO and column counter are flushed on this transition.
  - ROLL_LO: request the low byte; on ack latch it -> ROLL_HI.
  - ROLL_HI: request the high byte; on ack form base -> FETCH.
  - FETCH: issue a byte request whenever (fifo_count + outstanding) < FIFO_DEPTH. On ack push the byte and increment c. When c reaches LINE_BYTES -> IDLE.
- Linestart arriving mid-operation (not IDLE): go to DRAIN, hold the pending request until ack, discard its data, then take the ROLL_LO path. DRAIN with no request pending completes in one cycle.
- Linestart in vblank: flush FIFO, go to IDLE, issue no requests.
- Shifter (only on i_pix_stb & i_active):
  - If i_x[2:0]==0 and FIFO not empty: pop head; pixel=head[7]; sh<=head<<1.
  - If i_x[2:0]==0 and FIFO empty: pixel=0, sh<=0, set o_underrun.
  - Otherwise: pixel=sh[7]; sh<=sh<<1.
- Pixel output: o_pixel <= (pixel ^ i_invert) & i_disp_en. Outside i_active, o_pixel <= 0.
- Push and pop in the same cycle is legal; the count is unchanged.
- FIFO overflow is impossible by construction; a push when full is an implementation assertion error.
- o_underrun clears only on reset.

Test Plan:
- roller_base=0x1000, scroll=0, y=5; memory returns 0x34 at 0x100A and 0x12 at 0x100B -> requests 0x100A, 0x100B, then 0x02468, 0x02470, ... for 90 reads; last read at 0x02468+712=0x02730.
- scroll=0xFE, y=3 -> roller read address = base + 2 = 0x1002 (wrap mod 256).
- Screen byte 0xA5 at column 0, invert=0, disp_en=1 -> o_pixel for x=0..7 = 1,0,1,0,0,1,0,1, each one strobe late. Invert=1 gives the complement. disp_en=0 gives all 0.
- Ack withheld for 400 strobes past active start -> pixels 0 and o_underrun=1 latched until i_rst.
- Linestart asserted while a FETCH request awaits ack, ack returns 10 cycles later -> that data is discarded, then the new roller read issues; pixels of the new line are correct.
- i_rst pulsed mid-line -> o_mem_req=0 and o_pixel=0 asynchronously; the next linestart restarts cleanly. Linestart with vblank=1 -> no o_mem_req.
